// File: rtl/csmulti_mac_stage.sv
// ============================================================================
// Module   : csmulti_mac_stage (with csmulti_fullbasecell multiplier)
// Brief    : Pipelined multiply-accumulate stage over in_last-delimited frames.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module csmulti_fullbasecell #(
  parameter int BITSIZE = 8
) (
  input  logic [BITSIZE-1:0]   factor0,
  input  logic [BITSIZE-1:0]   factor1,
  output logic [2*BITSIZE-1:0] product
);

  logic [BITSIZE-1:0] w_sum   [BITSIZE];
  logic [BITSIZE-1:0] w_carry [BITSIZE];
  logic [BITSIZE-1:0] w_pp;
  logic [BITSIZE-1:0] w_in;
  logic [BITSIZE-1:0] w_lo;
  logic [BITSIZE-1:0] w_hi;

  // Each row is a rank of full adders: partial product, shifted sum of the
  // row above and its saved carries. Only the final row is carry-propagated.
  always_comb begin
    for (int r = 0; r < BITSIZE; r++) begin
      w_sum[r]   = '0;
      w_carry[r] = '0;
    end
    w_pp = '0;
    w_in = '0;
    w_lo = '0;
    for (int r = 0; r < BITSIZE; r++) begin
      w_pp = factor0 & {BITSIZE{factor1[r]}};
      if (r == 0) begin
        w_sum[r]   = w_pp;
        w_carry[r] = '0;
      end else begin
        w_in       = {1'b0, w_sum[r-1][BITSIZE-1:1]};
        w_sum[r]   = w_pp ^ w_in ^ w_carry[r-1];
        w_carry[r] = (w_pp & w_in) | (w_pp & w_carry[r-1]) | (w_in & w_carry[r-1]);
      end
      w_lo[r] = w_sum[r][0];
    end
    w_hi = {1'b0, w_sum[BITSIZE-1][BITSIZE-1:1]} + w_carry[BITSIZE-1];
  end

  assign product = {w_hi, w_lo};

endmodule

module csmulti_mac_stage #(
  parameter int BITSIZE     = 8,
  parameter int ACC_WIDTH   = 2*BITSIZE+4,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BITSIZE-1:0]     in_factor0,
  input  logic [BITSIZE-1:0]     in_factor1,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_acc,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   out_ovf
);

  logic [BITSIZE-1:0]     s1_f0_q, s1_f0_d;
  logic [BITSIZE-1:0]     s1_f1_q, s1_f1_d;
  logic                   s1_last_q, s1_last_d;
  logic                   s1_valid_q, s1_valid_d;
  logic [2*BITSIZE-1:0]   s2_prod_q, s2_prod_d;
  logic                   s2_last_q, s2_last_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0]   out_acc_q, out_acc_d;
  logic [COUNT_WIDTH-1:0] out_count_q, out_count_d;
  logic                   out_ovf_q, out_ovf_d;

  logic                   w_advance;
  logic                   w_accept;
  logic [2*BITSIZE-1:0]   w_product;
  logic [ACC_WIDTH:0]     w_prod_ext;
  logic [ACC_WIDTH:0]     w_sum;
  logic                   w_carry;
  logic [COUNT_WIDTH-1:0] w_cnt_inc;

  csmulti_fullbasecell #(
    .BITSIZE (BITSIZE)
  ) u_mult (
    .factor0 (s1_f0_q),
    .factor1 (s1_f1_q),
    .product (w_product)
  );

  // Whole pipeline stalls only while a result sits unconsumed.
  assign w_advance  = !out_valid_q || out_ready;
  assign w_accept   = in_valid && w_advance;
  assign w_prod_ext = (ACC_WIDTH+1)'(s2_prod_q);
  assign w_sum      = {1'b0, acc_q} + w_prod_ext;
  assign w_carry    = w_sum[ACC_WIDTH];
  assign w_cnt_inc  = (cnt_q == {COUNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + COUNT_WIDTH'(1);

  always_comb begin
    s1_f0_d     = s1_f0_q;
    s1_f1_d     = s1_f1_q;
    s1_last_d   = s1_last_q;
    s1_valid_d  = s1_valid_q;
    s2_prod_d   = s2_prod_q;
    s2_last_d   = s2_last_q;
    s2_valid_d  = s2_valid_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    if (w_advance) begin
      s1_f0_d     = in_factor0;
      s1_f1_d     = in_factor1;
      s1_last_d   = in_last;
      s1_valid_d  = w_accept;
      s2_prod_d   = w_product;
      s2_last_d   = s1_last_q;
      s2_valid_d  = s1_valid_q;
      out_valid_d = 1'b0;
      if (s2_valid_q) begin
        if (s2_last_q) begin
          // Frame end: publish and restart the accumulator on the same edge.
          out_acc_d   = w_sum[ACC_WIDTH-1:0];
          out_count_d = w_cnt_inc;
          out_ovf_d   = ovf_q | w_carry;
          out_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
        end else begin
          acc_d = w_sum[ACC_WIDTH-1:0];
          cnt_d = w_cnt_inc;
          ovf_d = ovf_q | w_carry;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_f0_q     <= '0;
      s1_f1_q     <= '0;
      s1_last_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s2_prod_q   <= '0;
      s2_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      s1_f0_q     <= s1_f0_d;
      s1_f1_q     <= s1_f1_d;
      s1_last_q   <= s1_last_d;
      s1_valid_q  <= s1_valid_d;
      s2_prod_q   <= s2_prod_d;
      s2_last_q   <= s2_last_d;
      s2_valid_q  <= s2_valid_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = w_advance;
  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_csmulti_mac_stage.sv
// ============================================================================
// Module   : tb_csmulti_mac_stage
// Brief    : Directed self-checking bench for csmulti_mac_stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_csmulti_mac_stage;

  localparam int BITSIZE     = 8;
  localparam int ACC_WIDTH   = 20;
  localparam int COUNT_WIDTH = 8;

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [BITSIZE-1:0]     in_factor0;
  logic [BITSIZE-1:0]     in_factor1;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_WIDTH-1:0]   out_acc;
  logic [COUNT_WIDTH-1:0] out_count;
  logic                   out_ovf;

  int n_total = 0;
  int n_bad   = 0;

  csmulti_mac_stage #(
    .BITSIZE     (BITSIZE),
    .ACC_WIDTH   (ACC_WIDTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_factor0 (in_factor0),
    .in_factor1 (in_factor1),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_acc    (out_acc),
    .out_count  (out_count),
    .out_ovf    (out_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int a, input int b, input bit last);
    in_valid   = 1'b1;
    in_factor0 = a[BITSIZE-1:0];
    in_factor1 = b[BITSIZE-1:0];
    in_last    = last;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check("out_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic check_result(input string tag, input int acc, input int cnt, input bit ovf);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_acc"},   32'(out_acc), 32'(acc));
    check({tag, "_count"}, 32'(out_count), 32'(cnt));
    check({tag, "_ovf"},   {31'd0, out_ovf}, {31'd0, ovf});
  endtask

  initial begin
    logic [15:0] bubbles;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_factor0 = '0;
    in_factor1 = '0;
    in_last    = 1'b0;
    out_ready  = 1'b1;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_acc",   32'(out_acc), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_ovf",   {31'd0, out_ovf}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Basic frame and latency
    beat(3, 5, 1'b0);
    beat(7, 9, 1'b0);
    beat(255, 255, 1'b1);
    idle();
    check("lat_t0", {31'd0, out_valid}, 32'd0);
    tick();
    check("lat_t1", {31'd0, out_valid}, 32'd0);
    tick();
    check_result("f1", 65103, 3, 1'b0);
    tick();
    check("f1_drop", {31'd0, out_valid}, 32'd0);

    // Back-to-back single-beat frames
    beat(0, 0, 1'b1);
    beat(12, 12, 1'b1);
    idle();
    tick();
    check_result("sb0", 0, 1, 1'b0);
    tick();
    check_result("sb1", 144, 1, 1'b0);
    tick();
    check("sb_drop", {31'd0, out_valid}, 32'd0);

    // Accumulator wrap
    for (int i = 0; i < 17; i++) beat(255, 255, i == 16);
    beat(1, 1, 1'b1);
    idle();
    tick();
    check_result("wrap", 56849, 17, 1'b1);
    tick();
    check_result("after_wrap", 1, 1, 1'b0);
    tick();
    check("wrap_drop", {31'd0, out_valid}, 32'd0);

    // Backpressure: result held while a pair waits at the input
    out_ready = 1'b0;
    beat(5, 6, 1'b1);
    beat(7, 1, 1'b1);
    beat(3, 3, 1'b1);
    in_valid   = 1'b1;
    in_factor0 = 8'd2;
    in_factor1 = 8'd5;
    in_last    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_acc", 32'(out_acc), 32'd30);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_resume_ready", {31'd0, in_ready}, 32'd1);
    tick();
    idle();
    check_result("bp_r7", 7, 1, 1'b0);
    tick();
    check_result("bp_r9", 9, 1, 1'b0);
    tick();
    check_result("bp_r10", 10, 1, 1'b0);
    tick();
    check("bp_drop", {31'd0, out_valid}, 32'd0);

    // Bubbles inside a frame
    bubbles = 16'b1011_0100_1101_0010;
    for (int i = 0; i < 10; i++) begin
      if (bubbles[i]) begin
        idle();
        tick();
      end
      beat(2, 3, i == 9);
    end
    idle();
    wait_out();
    check_result("bub", 60, 10, 1'b0);
    tick();

    // Asynchronous reset mid-frame with a pending result
    out_ready = 1'b0;
    beat(9, 9, 1'b1);
    beat(1, 1, 1'b0);
    beat(1, 1, 1'b0);
    idle();
    check("pre_rst_acc", 32'(out_acc), 32'd81);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_acc",   32'(out_acc), 32'd0);
    check("arst_count", 32'(out_count), 32'd0);
    check("arst_ovf",   {31'd0, out_ovf}, 32'd0);
    check("arst_ready", {31'd0, in_ready}, 32'd1);
    tick();
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    beat(4, 4, 1'b1);
    idle();
    wait_out();
    check_result("post_rst", 16, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
